// File: rtl/am_tx_safety_sequencer.sv
// AM transmit gain sequencer: arm/ramp/run/ramp-down/hold/fault around a watchdog trip.
// Latency 1 clk sample-to-output; no backpressure, every input sample is accepted.
module am_tx_safety_sequencer #(
    parameter int DATA_W      = 16,
    parameter int RAMP_STEP   = 16,
    parameter int WARN_GAIN   = 128,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     force_reset,
    input  logic                     warning,
    input  logic                     arm_req,
    input  logic signed [DATA_W-1:0] amp_in,
    input  logic                     amp_valid_in,
    output logic signed [DATA_W-1:0] amp_out,
    output logic                     amp_valid_out,
    output logic                     tx_enable,
    output logic                     fault_latched,
    output logic [2:0]               state,
    output logic [7:0]               fault_count
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int          HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [8:0]  GAIN_FULL = 9'd256;
    localparam logic [8:0]  GAIN_WARN = 9'(WARN_GAIN);
    localparam logic [9:0]  STEP10    = 10'(RAMP_STEP);
    localparam logic [8:0]  STEP9     = 9'(RAMP_STEP);
    localparam int          PROD_W    = DATA_W + 9;

    logic [2:0]              r_state;
    logic [8:0]              r_gain;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [7:0]              r_fault_count;
    logic signed [DATA_W-1:0] r_amp_out;
    logic                    r_amp_valid_out;

    logic [2:0]              w_state_nxt;
    logic [8:0]              w_gain_nxt;
    logic [HOLD_W-1:0]       w_hold_nxt;
    logic                    w_enter_down;
    logic [PROD_W-1:0]       w_amp_ext;
    logic [PROD_W-1:0]       w_gain_ext;
    logic signed [PROD_W-1:0] w_prod;

    // One saturating step of cur toward tgt; never overshoots in either direction.
    function automatic logic [8:0] f_step(input logic [8:0] cur, input logic [8:0] tgt);
        logic [9:0] v_up;
        logic [9:0] v_floor;
        v_up    = {1'b0, cur} + STEP10;
        v_floor = {1'b0, tgt} + STEP10;
        if (cur < tgt)
            f_step = (v_up >= {1'b0, tgt}) ? tgt : v_up[8:0];
        else if (cur > tgt)
            f_step = ({1'b0, cur} <= v_floor) ? tgt : (cur - STEP9);
        else
            f_step = cur;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_IDLE, ST_FAULT: begin
                w_gain_nxt = 9'd0;
                if (arm_req && !force_reset)
                    w_state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (force_reset) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end else begin
                    w_gain_nxt = f_step(r_gain, GAIN_FULL);
                    if (w_gain_nxt == GAIN_FULL)
                        w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (force_reset)
                    w_state_nxt = ST_RAMP_DOWN;
                else
                    w_gain_nxt = f_step(r_gain, warning ? GAIN_WARN : GAIN_FULL);
            end
            ST_RAMP_DOWN: begin
                w_gain_nxt = f_step(r_gain, 9'd0);
                if (w_gain_nxt == 9'd0) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                w_gain_nxt = 9'd0;
                if (r_hold_cnt == '0)
                    w_state_nxt = ST_FAULT;
                else
                    w_hold_nxt = r_hold_cnt - 1'b1;
            end
            default: w_state_nxt = ST_RAMP_DOWN;
        endcase
    end

    assign w_enter_down = (w_state_nxt == ST_RAMP_DOWN) && (r_state != ST_RAMP_DOWN);

    // Gain is zero-extended so the product stays signed; |amp*256| fits in PROD_W.
    assign w_amp_ext  = {{9{amp_in[DATA_W-1]}}, amp_in};
    assign w_gain_ext = {{DATA_W{1'b0}}, r_gain};
    assign w_prod     = $signed(w_amp_ext) * $signed(w_gain_ext);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= ST_IDLE;
            r_gain          <= 9'd0;
            r_hold_cnt      <= '0;
            r_fault_count   <= 8'd0;
            r_amp_out       <= '0;
            r_amp_valid_out <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_gain          <= w_gain_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_amp_out       <= DATA_W'(w_prod >>> 8);
            r_amp_valid_out <= amp_valid_in;
            if (w_enter_down && (r_fault_count != 8'hFF))
                r_fault_count <= r_fault_count + 8'd1;
        end
    end

    assign state         = r_state;
    assign tx_enable     = (r_state == ST_RAMP_UP) || (r_state == ST_RUN) ||
                           (r_state == ST_RAMP_DOWN);
    assign fault_latched = (r_state == ST_FAULT);
    assign fault_count   = r_fault_count;
    assign amp_out       = r_amp_out;
    assign amp_valid_out = r_amp_valid_out;

endmodule
